// File: rtl/seg7_scan4.sv
// Four-digit common-anode seven-segment scanner for the BCD wall clock.
// Frames come from a snapshot taken on each 3->0 wrap, so time never tears.
module seg7_scan4 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int LZ_BLANK  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mu,
    input  logic [3:0] md,
    input  logic [3:0] hu,
    input  logic [3:0] hd,
    input  logic       sec_tick,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_V  = DW'(BLANK_CYC);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic          colon_q, colon_d;
    logic [3:0]    snap_q [4];
    logic [3:0]    snap_d [4];
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          last;
    logic          en;
    logic [3:0]    digit;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        last    = (div_q == DIV_LAST);
        div_d   = last ? '0 : div_q + 1'b1;
        idx_d   = last ? idx_q + 2'd1 : idx_q;
        colon_d = colon_q ^ sec_tick;
        snap_d  = snap_q;
        if (last && (idx_q == 2'd3)) begin
            snap_d[0] = mu;
            snap_d[1] = md;
            snap_d[2] = hu;
            snap_d[3] = hd;
        end
        // anodes stay dark for the first BLANK_CYC cycles of each slot
        en    = (BLANK_CYC == 0) || (div_q >= BLANK_V);
        digit = snap_q[idx_q];
        an_d  = 4'b1111;
        if (en) an_d[idx_q] = 1'b0;
        seg_d = dec(digit);
        if ((LZ_BLANK != 0) && (idx_q == 2'd3) && (digit == 4'd0))
            seg_d = 7'b1111111;
        dp_d = !((idx_q == 2'd2) && colon_q && en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            idx_q   <= '0;
            colon_q <= 1'b0;
            snap_q  <= '{default: 4'd0};
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            colon_q <= colon_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4: a frame/slot arithmetic model predicts
// every registered output; a negedge monitor compares two LZ variants.
module tb_seg7_scan4;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FR = 4 * SD;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg1;
        logic [6:0] seg0;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] mu = 4'd8;
    logic [3:0] md = 4'd5;
    logic [3:0] hu = 4'd3;
    logic [3:0] hd = 4'd2;
    logic       sec_tick = 1'b0;
    logic [6:0] seg1, seg0;
    logic [3:0] an1, an0;
    logic       dp1, dp0;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    int         p = 0;
    logic [3:0] msnap [4] = '{default: 4'd0};
    bit         mcolon = 1'b0;

    always #5 clk = ~clk;

    seg7_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1)) u_lz1 (
        .clk(clk), .rst(rst), .mu(mu), .md(md), .hu(hu), .hd(hd),
        .sec_tick(sec_tick), .seg(seg1), .an(an1), .dp(dp1)
    );

    seg7_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(0)) u_lz0 (
        .clk(clk), .rst(rst), .mu(mu), .md(md), .hu(hu), .hd(hd),
        .sec_tick(sec_tick), .seg(seg0), .an(an0), .dp(dp0)
    );

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    endfunction

    // Predict the outputs after the coming edge, then advance the model.
    task automatic cyc(input logic r, input logic t);
        exp_t e;
        int   slot, off;
        bit   on;
        rst      = r;
        sec_tick = t;
        if (!r) begin
            e.an = 4'b1111; e.seg1 = 7'h7F;
            e.seg0 = 7'h7F; e.dp = 1'b1;
            p = 0; mcolon = 1'b0;
            msnap = '{default: 4'd0};
        end else begin
            slot = (p / SD) % 4;
            off  = p % SD;
            on   = (off >= BC);
            e.an = on ? ~(4'b0001 << slot) : 4'b1111;
            e.seg0 = glyph(msnap[slot]);
            e.seg1 = (slot == 3 && msnap[slot] == 0) ? 7'h7F : e.seg0;
            e.dp = !(slot == 2 && mcolon && on);
            if (t) mcolon = !mcolon;
            if (p % FR == FR - 1) begin
                msnap[0] = mu; msnap[1] = md;
                msnap[2] = hu; msnap[3] = hd;
            end
            p++;
        end
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (an1 === e.an && seg1 === e.seg1 && dp1 === e.dp)
                passed++;
            else
                $display("FAIL lz1 t=%0t an=%b want %b seg=%b want %b dp=%b want %b",
                         $time, an1, e.an, seg1, e.seg1, dp1, e.dp);
            checks++;
            if (an0 === e.an && seg0 === e.seg0 && dp0 === e.dp)
                passed++;
            else
                $display("FAIL lz0 t=%0t an=%b want %b seg=%b want %b dp=%b want %b",
                         $time, an0, e.an, seg0, e.seg0, dp0, e.dp);
        end
    end

    initial begin
        @(negedge clk);
        #1;
        repeat (3) cyc(1'b0, 1'b0);
        repeat (2 * FR) cyc(1'b1, 1'b0);
        while ((p / SD) % 4 != 1) cyc(1'b1, 1'b0);
        mu = 4'd9;
        repeat (2 * FR) cyc(1'b1, 1'b0);
        hd = 4'd0; hu = 4'd9; md = 4'd0; mu = 4'd12;
        repeat (2 * FR) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (FR) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (FR) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (FR) cyc(1'b1, 1'b0);
        hd = 4'd1; hu = 4'd2; md = 4'd4; mu = 4'd7;
        cyc(1'b1, 1'b1);
        repeat (FR + 3) cyc(1'b1, 1'b0);
        while (p % FR != 2 * SD + 2) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        repeat (2 * FR) cyc(1'b1, 1'b0);
        repeat (800) begin
            hd = 4'($urandom_range(0, 15));
            hu = 4'($urandom_range(0, 15));
            md = 4'($urandom_range(0, 15));
            mu = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 149) != 0),
                ($urandom_range(0, 5) == 0));
        end
        @(negedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain left=%0d want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan4.md
Name: seg7_scan4

Overview:
- Downstream display stage for the BCD wall clock.
- Consumes the four clock digits (minute units/tens, hour units/tens) and drives a common-anode, 4-digit, time-multiplexed seven-segment display.
- Contains a scan prescaler, a digit sequencer, an anti-ghosting blank window, a tear-free digit snapshot, BCD-to-segment decode, leading-zero blanking and a blinking colon point.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; legal range 2 and up.
- BLANK_CYC, 500: cycles at the start of each slot during which all anodes are off; legal range 0 to SCAN_DIV-1.
- LZ_BLANK, 1: when 1, the hour-tens digit is blanked while it equals 0.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
- mu, in, 4: minute units, BCD.
- md, in, 4: minute tens, BCD.
- hu, in, 4: hour units, BCD.
- hd, in, 4: hour tens, BCD.
- sec_tick, in, 1: one-cycle pulse, once per second.
- seg, out, 7: segments {g,f,e,d,c,b,a}; active-low (0 = lit).
- an, out, 4: anode enables, bit0 = mu position … bit3 = hd position; active-low.
- dp, out, 1: decimal point, active-low; used as the colon and shown on the hu position.

Behaviour:
- **Reset (rst=0 at a clk edge):** all state and outputs take reset values at that edge.
  - div=0, idx=0, colon=0, snapshot={0,0,0,0}.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Reset mid-scan aborts the current slot; the first post-reset slot is idx 0.
- **Prescaler:** div counts 0..SCAN_DIV-1 and wraps to 0. When div==SCAN_DIV-1, idx advances on the same edge.
- **Digit index:** idx sequence is 0→1→2→3→0, mapping mu, md, hu, hd.
- **Snapshot:** on the edge where idx wraps 3→0, mu/md/hu/hd are captured into the snapshot.
  - Display data comes only from the snapshot, so a whole frame shows one consistent time.
  - The first frame after reset displays 00:00 (hd blanked if LZ_BLANK=1).
  - The last snapshot is retained indefinitely.
- **Colon:** colon toggles on every cycle where sec_tick=1. If sec_tick coincides with reset, reset wins.
- **Registered outputs:** outputs are registered and lag div/idx by one cycle.
  - an: while div < BLANK_CYC, an=4'b1111. Otherwise an has only bit idx low.
  - seg: the decode of snapshot[idx].
  - dp: 0 only when idx==2 and colon==1 and anodes are enabled; otherwise 1.
- **Decode (active-low, {g..a}):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10..15 show a dash: 0111111.
- **Leading-zero blank:** if LZ_BLANK=1 and idx==3 and snapshot hd==0, then seg=1111111 while an still follows the normal rule. Applies to hd only.
- **Zero blank window:** BLANK_CYC=0 means no blank window; an is asserted for the full slot.
- **Timing summary:**
  - Slot length is exactly SCAN_DIV cycles.
  - Frame length is 4*SCAN_DIV cycles.
  - The anode on-time per slot is SCAN_DIV-BLANK_CYC cycles.
- **Width rules:**
  - div is sized with $clog2(SCAN_DIV) bits, and its terminal compare must not overflow.
  - Input changes mid-frame never alter the current frame.

Test Plan:
1. **Reset then release:**
   - Stimulus: SCAN_DIV=4, BLANK_CYC=1, LZ_BLANK=1; hold rst=0 for 3 cycles with inputs 2,3,5,8 (hd,hu,md,mu); release.
   - Required: an=1111, seg=1111111, dp=1 during reset.
   - First frame: an=1110 with seg=1000000 after the 1-cycle blank; 4 cycles later an=1101.
2. **Snapshot and scan order:**
   - Stimulus: same setup as scenario 1; continue to the second frame.
   - Required, per slot: an=1110/seg=0000000 (8), an=1101/seg=0010010 (5), an=1011/seg=0110000 (3), an=0111/seg=0100100 (2).
   - Each slot's first cycle has an=1111.
3. **Tear-free update:**
   - Stimulus: change mu from 8 to 9 while idx=1.
   - Required: the rest of the frame still shows 8 at the mu slot; 9 appears only after the next 3→0 wrap.
4. **Leading zero and invalid code:**
   - Stimulus: hd=0, hu=9, md=0, mu=12.
   - Required: hd slot has an=0111, seg=1111111; mu slot shows 0111111 (dash); md slot shows 1000000.
   - With LZ_BLANK=0, the hd slot shows 1000000.
5. **Colon:**
   - Stimulus: pulse sec_tick once.
   - Required: dp=0 only during the enabled hu slot (an=1011).
   - A second pulse returns dp=1 everywhere. A sec_tick pulse with rst=0 leaves colon=0.
6. **Reset mid-slot:**
   - Stimulus: assert rst=0 for 1 cycle during idx=2, div=2.
   - Required: the next edge gives an=1111/seg=1111111/dp=1, and the scan restarts at idx 0 with a displayed 00:00 frame.
